// File: rtl/link_bist.sv
// link_bist: synthesizable link traffic generator (tx side) and self-synchronising
// pattern checker (rx side) with saturating word, word-error and bit-error counters.
module link_bist #(
  parameter int unsigned        DATA_W      = 8,
  parameter logic [DATA_W-1:0]  POLY        = DATA_W'(8'hB8),
  parameter logic [DATA_W-1:0]  SEED        = DATA_W'(1),
  parameter logic [DATA_W-1:0]  PATTERN     = DATA_W'(8'hBC),
  parameter int unsigned        LOCK_COUNT  = 4,
  parameter int unsigned        UNLOCK_ERRS = 4,
  parameter int unsigned        CNT_W       = 16
) (
  input  logic              clk_bit,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              clear,
  output logic [DATA_W-1:0] tx_din,
  output logic              tx_din_valid,
  input  logic              tx_read_enable,
  input  logic [DATA_W-1:0] rx_d,
  input  logic              rx_valid,
  input  logic              rx_reframe,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  word_err_cnt,
  output logic [CNT_W-1:0]  bit_err_cnt
);

  localparam int unsigned PC_W    = $clog2(DATA_W + 1);
  localparam int unsigned SUM_W   = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam int unsigned MATCH_W = (LOCK_COUNT  > 1) ? $clog2(LOCK_COUNT)  : 1;
  localparam int unsigned MISS_W  = (UNLOCK_ERRS > 1) ? $clog2(UNLOCK_ERRS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Next word of the selected pattern.
  function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] x,
                                                  input logic [1:0]        m);
    logic [DATA_W-1:0] n;
    case (m)
      2'd0:    n = x + DATA_W'(1);
      2'd1:    n = (x >> 1) ^ (x[0] ? POLY : '0);
      2'd2:    n = PATTERN;
      default: n = {x[DATA_W-2:0], x[DATA_W-1]};
    endcase
    return n;
  endfunction

  // First word emitted after enable or a pattern switch.
  function automatic logic [DATA_W-1:0] seed_word(input logic [1:0] m);
    logic [DATA_W-1:0] s;
    case (m)
      2'd0:    s = '0;
      2'd1:    s = SEED;
      2'd2:    s = PATTERN;
      default: s = DATA_W'(1);
    endcase
    return s;
  endfunction

  // Number of set bits in a word.
  function automatic logic [PC_W-1:0] popcount(input logic [DATA_W-1:0] x);
    logic [PC_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      c = c + PC_W'(x[i]);
    end
    return c;
  endfunction

  logic              enable_q;
  logic [1:0]        mode_q;
  chk_state_t        state;
  logic [DATA_W-1:0] expected;
  logic [MATCH_W-1:0] match_cnt;
  logic [MISS_W-1:0] miss_cnt;

  logic              mode_chg;
  logic              force_hunt;
  logic              word_miss;
  logic [DATA_W-1:0] exp_next;
  logic [DATA_W-1:0] rx_next;
  logic [PC_W-1:0]   diff_bits;
  logic              word_upd;
  logic [CNT_W-1:0]  word_cnt_inc;
  logic [CNT_W-1:0]  word_err_inc;
  logic [SUM_W-1:0]  bit_sum;
  logic [CNT_W-1:0]  bit_err_add;

  // Shared decode for the checker and counters.
  assign mode_chg   = (mode != mode_q);
  assign force_hunt = rx_reframe | ~enable | mode_chg;
  assign word_miss  = (rx_d != expected);
  assign exp_next   = next_word(expected, mode);
  assign rx_next    = next_word(rx_d, mode);
  assign diff_bits  = popcount(rx_d ^ expected);
  assign word_upd   = rx_valid & ~force_hunt & (state == LOCKED);

  // Saturating increments; the bit sum is formed one bit wider so it cannot wrap.
  assign word_cnt_inc = (word_cnt     == CNT_MAX) ? CNT_MAX : word_cnt + CNT_W'(1);
  assign word_err_inc = (word_err_cnt == CNT_MAX) ? CNT_MAX : word_err_cnt + CNT_W'(1);
  assign bit_sum      = SUM_W'(bit_err_cnt) + SUM_W'(diff_bits);
  assign bit_err_add  = (bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(bit_sum);

  // Generator: seed on enable rise or pattern switch, advance when tx takes the word.
  always_ff @(posedge clk_bit or negedge rst_n) begin
    if (!rst_n) begin
      tx_din       <= '0;
      tx_din_valid <= 1'b0;
      enable_q     <= 1'b0;
      mode_q       <= 2'd0;
    end else begin
      enable_q <= enable;
      mode_q   <= mode;
      if (!enable) begin
        tx_din_valid <= 1'b0;
      end else if (!enable_q || mode_chg) begin
        tx_din       <= seed_word(mode);
        tx_din_valid <= 1'b1;
      end else if (tx_din_valid && tx_read_enable) begin
        tx_din <= next_word(tx_din, mode);
      end
    end
  end

  // Checker FSM: hunt for a seed word, confirm LOCK_COUNT matches, then track.
  always_ff @(posedge clk_bit or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (force_hunt) begin
        state  <= HUNT;
        locked <= 1'b0;
      end else if (rx_valid) begin
        case (state)
          HUNT: begin
            expected  <= rx_next;
            match_cnt <= '0;
            state     <= SYNC;
          end
          SYNC: begin
            if (!word_miss) begin
              expected <= exp_next;
              if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + MATCH_W'(1);
              end
            end else begin
              expected  <= rx_next;
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            expected <= exp_next;
            if (word_miss) begin
              err_pulse <= 1'b1;
              if (miss_cnt == MISS_W'(UNLOCK_ERRS - 1)) begin
                state  <= HUNT;
                locked <= 1'b0;
              end else begin
                miss_cnt <= miss_cnt + MISS_W'(1);
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Statistics counters; clear overrides any concurrent update.
  always_ff @(posedge clk_bit or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt     <= '0;
      word_err_cnt <= '0;
      bit_err_cnt  <= '0;
    end else if (clear) begin
      word_cnt     <= '0;
      word_err_cnt <= '0;
      bit_err_cnt  <= '0;
    end else if (word_upd) begin
      word_cnt <= word_cnt_inc;
      if (word_miss) begin
        word_err_cnt <= word_err_inc;
        bit_err_cnt  <= bit_err_add;
      end
    end
  end

endmodule

// File: tb/tb_link_bist.sv
// tb_link_bist: randomized bench for link_bist with a behavioural model and a
// scoreboard queue drained by an independent monitor; a CNT_W=4 copy shares stimulus.
module tb_link_bist;

  localparam logic [7:0] POLY     = 8'hB8;
  localparam logic [7:0] SEED     = 8'h01;
  localparam logic [7:0] PATTERN  = 8'hBC;
  localparam int         LOCK_N   = 4;
  localparam int         UNLOCK_N = 4;

  logic       clk_bit = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       clear = 1'b0;
  logic       tx_read_enable = 1'b0;
  logic [7:0] rx_d = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_reframe = 1'b0;

  logic [7:0]  tx_din, tx_din_s;
  logic        tx_din_valid, tx_din_valid_s;
  logic        locked, locked_s, err_pulse, err_pulse_s;
  logic [15:0] word_cnt, word_err_cnt, bit_err_cnt;
  logic [3:0]  word_cnt_s, word_err_cnt_s, bit_err_cnt_s;

  link_bist #(.DATA_W(8), .POLY(POLY), .SEED(SEED), .PATTERN(PATTERN),
              .LOCK_COUNT(LOCK_N), .UNLOCK_ERRS(UNLOCK_N), .CNT_W(16)) dut (
    .clk_bit(clk_bit), .rst_n(rst_n), .enable(enable), .mode(mode), .clear(clear),
    .tx_din(tx_din), .tx_din_valid(tx_din_valid), .tx_read_enable(tx_read_enable),
    .rx_d(rx_d), .rx_valid(rx_valid), .rx_reframe(rx_reframe),
    .locked(locked), .err_pulse(err_pulse), .word_cnt(word_cnt),
    .word_err_cnt(word_err_cnt), .bit_err_cnt(bit_err_cnt));

  link_bist #(.DATA_W(8), .POLY(POLY), .SEED(SEED), .PATTERN(PATTERN),
              .LOCK_COUNT(LOCK_N), .UNLOCK_ERRS(UNLOCK_N), .CNT_W(4)) dut_s (
    .clk_bit(clk_bit), .rst_n(rst_n), .enable(enable), .mode(mode), .clear(clear),
    .tx_din(tx_din_s), .tx_din_valid(tx_din_valid_s), .tx_read_enable(tx_read_enable),
    .rx_d(rx_d), .rx_valid(rx_valid), .rx_reframe(rx_reframe),
    .locked(locked_s), .err_pulse(err_pulse_s), .word_cnt(word_cnt_s),
    .word_err_cnt(word_err_cnt_s), .bit_err_cnt(bit_err_cnt_s));

  always #5 clk_bit = ~clk_bit;

  typedef struct {
    logic [7:0] tx;
    logic       txv;
    logic       lk;
    logic       ep;
    int         wc;
    int         we;
    int         be;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state
  logic [7:0] g_word;
  logic       g_valid;
  logic       g_en_prev;
  logic [1:0] g_mode_prev;
  int         c_phase;     // 0 searching, 1 confirming, 2 tracking
  logic [7:0] c_exp;
  int         c_match;
  int         c_miss;
  logic       c_pulse;
  int         n_word, n_werr, n_berr;
  logic [7:0] strm;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [7:0] m_next(input logic [7:0] x, input logic [1:0] m);
    int v;
    case (m)
      2'd0:    v = (int'(x) + 1) % 256;
      2'd1:    v = (int'(x) / 2) ^ (((int'(x) % 2) == 1) ? int'(POLY) : 0);
      2'd2:    v = int'(PATTERN);
      default: v = (int'(x) * 2) % 256 + int'(x) / 128;
    endcase
    return 8'(v);
  endfunction

  function automatic logic [7:0] seed_of(input logic [1:0] m);
    case (m)
      2'd0:    return 8'h00;
      2'd1:    return SEED;
      2'd2:    return PATTERN;
      default: return 8'h01;
    endcase
  endfunction

  task automatic model_reset();
    g_word = 8'h00; g_valid = 1'b0; g_en_prev = 1'b0; g_mode_prev = 2'd0;
    c_phase = 0; c_exp = 8'h00; c_match = 0; c_miss = 0; c_pulse = 1'b0;
    n_word = 0; n_werr = 0; n_berr = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic forced;
    logic hit;
    if (!rst_n) begin
      model_reset();
      return;
    end
    forced  = rx_reframe || !enable || (mode != g_mode_prev);
    hit     = (rx_d == c_exp);
    c_pulse = 1'b0;
    if (forced) begin
      c_phase = 0;
    end else if (rx_valid) begin
      if (c_phase == 0) begin
        c_exp = m_next(rx_d, mode); c_match = 0; c_phase = 1;
      end else if (c_phase == 1) begin
        if (hit) begin
          c_match++;
          c_exp = m_next(c_exp, mode);
          if (c_match == LOCK_N) begin c_phase = 2; c_miss = 0; end
        end else begin
          c_exp = m_next(rx_d, mode); c_match = 0;
        end
      end else begin
        n_word++;
        if (!hit) begin
          n_werr++;
          n_berr += $countones(rx_d ^ c_exp);
          c_pulse = 1'b1;
          c_miss++;
          if (c_miss == UNLOCK_N) c_phase = 0;
        end else begin
          c_miss = 0;
        end
        c_exp = m_next(c_exp, mode);
      end
    end
    if (clear) begin n_word = 0; n_werr = 0; n_berr = 0; end
    if (!enable) g_valid = 1'b0;
    else if (!g_en_prev || (mode != g_mode_prev)) begin g_word = seed_of(mode); g_valid = 1'b1; end
    else if (g_valid && tx_read_enable) g_word = m_next(g_word, mode);
    g_en_prev   = enable;
    g_mode_prev = mode;
  endtask

  // One clock of stimulus: predict, push the expectation, wait for the next falling edge.
  task automatic tick();
    exp_t e;
    model_step();
    e.tx = g_word; e.txv = g_valid; e.lk = (c_phase == 2); e.ep = c_pulse;
    e.wc = n_word; e.we = n_werr; e.be = n_berr;
    sbq.push_back(e);
    @(negedge clk_bit);
  endtask

  task automatic send(input logic [7:0] w);
    rx_d = w; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_good();
    send(strm);
    strm = m_next(strm, mode);
  endtask

  task automatic send_bad();
    send(strm ^ 8'($urandom_range(1, 255)));
    strm = m_next(strm, mode);
  endtask

  // Monitor: compare every registered output after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_bit);
      #1;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("tx_din_valid", 32'(tx_din_valid), 32'(e.txv));
        chk("tx_din", 32'(tx_din), 32'(e.tx));
        chk("locked", 32'(locked), 32'(e.lk));
        chk("err_pulse", 32'(err_pulse), 32'(e.ep));
        chk("word_cnt", 32'(word_cnt), sat(e.wc, 65535));
        chk("word_err_cnt", 32'(word_err_cnt), sat(e.we, 65535));
        chk("bit_err_cnt", 32'(bit_err_cnt), sat(e.be, 65535));
        chk("small_tx_din", {23'd0, tx_din_valid_s, tx_din_s}, {23'd0, e.txv, e.tx});
        chk("small_flags", {30'd0, locked_s, err_pulse_s}, {30'd0, e.lk, e.ep});
        chk("small_word_cnt", 32'(word_cnt_s), sat(e.wc, 15));
        chk("small_word_err_cnt", 32'(word_err_cnt_s), sat(e.we, 15));
        chk("small_bit_err_cnt", 32'(bit_err_cnt_s), sat(e.be, 15));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         nw;
    logic [7:0] seen[$];
    bit         was_valid;

    model_reset();
    strm = 8'h00;
    @(negedge clk_bit);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    tick();

    // Loopback, counter pattern, tx consumes every 10th cycle
    enable = 1'b1; mode = 2'd0; nw = 0;
    for (int c = 0; c < 3000 && nw < 256; c++) begin
      tx_read_enable = (c % 10 == 9);
      rx_valid = g_valid && tx_read_enable;
      rx_d = g_word;
      was_valid = rx_valid;
      tick();
      if (was_valid) begin
        nw++;
        if (nw == 4) chk("loop_not_locked_4", 32'(locked), 32'd0);
        if (nw == 5) chk("loop_locked_5", 32'(locked), 32'd1);
      end
    end
    rx_valid = 1'b0; tx_read_enable = 1'b0;
    chk("loop_words", nw, 256);
    chk("loop_word_cnt", 32'(word_cnt), 32'd251);
    chk("loop_word_err_cnt", 32'(word_err_cnt), 32'd0);
    chk("loop_small_word_cnt", 32'(word_cnt_s), 32'd15);

    // Loopback, PRBS, random tx consumption; capture the first emitted words
    mode = 2'd1;
    for (int c = 0; c < 400; c++) begin
      tx_read_enable = (c != 0) && ($urandom_range(0, 2) == 0);
      if (tx_din_valid && tx_read_enable) seen.push_back(tx_din);
      rx_valid = g_valid && tx_read_enable;
      rx_d = g_word;
      tick();
    end
    rx_valid = 1'b0; tx_read_enable = 1'b0;
    chk("prbs_len", 32'(seen.size() >= 4), 32'd1);
    if (seen.size() >= 4) begin
      chk("prbs_w0", 32'(seen[0]), 32'h01);
      chk("prbs_w1", 32'(seen[1]), 32'hB8);
      chk("prbs_w2", 32'(seen[2]), 32'h5C);
      chk("prbs_w3", 32'(seen[3]), 32'h2E);
    end
    chk("prbs_loop_locked", 32'(locked), 32'd1);

    // PRBS lock from an arbitrary offset
    rx_reframe = 1'b1; tick(); rx_reframe = 1'b0;
    strm = SEED;
    for (int k = $urandom_range(0, 254); k > 0; k--) strm = m_next(strm, 2'd1);
    for (int k = 0; k < 4; k++) send_good();
    chk("prbs_offset_not_yet", 32'(locked), 32'd0);
    send_good();
    chk("prbs_offset_locked", 32'(locked), 32'd1);

    // Counter pattern, single word with bits 0 and 3 flipped
    mode = 2'd0; tick();
    strm = 8'($urandom);
    for (int k = 0; k < 6; k++) send_good();
    clear = 1'b1; tick(); clear = 1'b0;
    send(strm ^ 8'h09); strm = m_next(strm, mode);
    chk("flip_pulse", 32'(err_pulse), 32'd1);
    chk("flip_word_err", 32'(word_err_cnt), 32'd1);
    chk("flip_bit_err", 32'(bit_err_cnt), 32'd2);
    send_good();
    chk("flip_pulse_once", 32'(err_pulse), 32'd0);
    for (int k = 0; k < 3; k++) send_good();
    chk("flip_word_err_hold", 32'(word_err_cnt), 32'd1);
    chk("flip_still_locked", 32'(locked), 32'd1);

    // Four consecutive bad words drop lock; five good words relock
    for (int k = 0; k < 3; k++) send_bad();
    chk("unlock_3_bad", 32'(locked), 32'd1);
    send_bad();
    chk("unlock_4_bad", 32'(locked), 32'd0);
    for (int k = 0; k < 4; k++) send_good();
    chk("relock_4_good", 32'(locked), 32'd0);
    send_good();
    chk("relock_5_good", 32'(locked), 32'd1);

    // Reframe while locked drops lock and the concurrent word
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 0; k < 3; k++) send_good();
    chk("pre_reframe_cnt", 32'(word_cnt), 32'd3);
    rx_reframe = 1'b1; send_good(); rx_reframe = 1'b0;
    chk("reframe_unlock", 32'(locked), 32'd0);
    chk("reframe_not_counted", 32'(word_cnt), 32'd3);

    // Clear coinciding with a mismatch
    for (int k = 0; k < 5; k++) send_good();
    clear = 1'b1; send_bad(); clear = 1'b0;
    chk("clr_word_cnt", 32'(word_cnt), 32'd0);
    chk("clr_word_err", 32'(word_err_cnt), 32'd0);
    chk("clr_bit_err", 32'(bit_err_cnt), 32'd0);
    chk("clr_locked", 32'(locked), 32'd1);

    // Twenty isolated mismatches: small counters saturate at 15
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 0; k < 20; k++) begin send_bad(); send_good(); end
    chk("sat_word_err", 32'(word_err_cnt), 32'd20);
    chk("sat_small_word_err", 32'(word_err_cnt_s), 32'd15);
    chk("sat_small_bit_err", 32'(bit_err_cnt_s), 32'd15);
    chk("sat_small_word_cnt", 32'(word_cnt_s), 32'd15);
    chk("sat_locked", 32'(locked), 32'd1);

    // Random soak over all controls
    for (int c = 0; c < 3000; c++) begin
      enable = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 199) == 0) mode = 2'($urandom);
      rx_reframe = ($urandom_range(0, 149) == 0);
      clear = ($urandom_range(0, 299) == 0);
      tx_read_enable = 1'($urandom);
      if ($urandom_range(0, 9) < 7) begin
        rx_valid = 1'b1;
        rx_d = ($urandom_range(0, 19) == 0) ? (strm ^ 8'($urandom_range(1, 255))) : strm;
        strm = m_next(strm, mode);
      end else begin
        rx_valid = 1'b0;
      end
      tick();
    end
    enable = 1'b1; rx_reframe = 1'b0; clear = 1'b0; rx_valid = 1'b0;

    // Asynchronous reset mid-run from a busy state
    mode = 2'd3; tx_read_enable = 1'b1; tick(); tick(); tick();
    strm = 8'h01;
    for (int k = 0; k < 6; k++) send_good();
    send_bad(); send_good();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tx", {23'd0, tx_din_valid, tx_din}, 32'd0);
    chk("arst_flags", {30'd0, locked, err_pulse}, 32'd0);
    chk("arst_cnts", {word_cnt, word_err_cnt}, 32'd0);
    chk("arst_bit_err", 32'(bit_err_cnt), 32'd0);
    chk("arst_small", {20'd0, word_cnt_s, word_err_cnt_s, bit_err_cnt_s}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rx_valid = g_valid && tx_read_enable;
      rx_d = g_word;
      tick();
    end
    rx_valid = 1'b0;
    chk("post_rst_locked", 32'(locked), 32'd1);
    chk("sb_drained", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/link_bist.md
# link_bist

Parametrised built-in self-test for the optical link: a pattern generator that feeds the `tx` data port and a self-synchronising checker that consumes the `rx` data port. It replaces hand-written stimulus loops with synthesizable traffic so link bring-up can run on hardware. Both halves run on one clock. The rx-side inputs arrive already synchronous to `clk_bit`, retimed by the CDC path outside this block.

## Interface
- `DATA_W`, 8: word width. Range 2..32.
- `POLY`, 8'hB8: Galois LFSR feedback mask for PRBS mode. `DATA_W` bits wide; bit `DATA_W-1` set.
- `SEED`, 1: PRBS start word. Non-zero.
- `PATTERN`, 8'hBC: word for fixed mode.
- `LOCK_COUNT`, 4: consecutive matches needed to lock. Minimum 1.
- `UNLOCK_ERRS`, 4: consecutive mismatches that drop lock. Minimum 1.
- `CNT_W`, 16: width of every counter.

Ports:
- `clk_bit`  in  1  bit clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run generator and checker.
- `mode`  in  2  pattern select: 0 counter, 1 PRBS, 2 fixed, 3 walking-one.
- `clear`  in  1  synchronous clear of all counters.
- `tx_din`  out  DATA_W  word to tx.
- `tx_din_valid`  out  1  word valid.
- `tx_read_enable`  in  1  tx consumes the word this cycle.
- `rx_d`  in  DATA_W  received word.
- `rx_valid`  in  1  `rx_d` valid.
- `rx_reframe`  in  1  rx lost framing.
- `locked`  out  1  checker in LOCKED state.
- `err_pulse`  out  1  one-cycle pulse per mismatched word while LOCKED.
- `word_cnt`  out  CNT_W  words checked while LOCKED.
- `word_err_cnt`  out  CNT_W  mismatched words.
- `bit_err_cnt`  out  CNT_W  sum of popcount(`rx_d` ^ expected) over mismatches.

## Operation
- Next-word function `next(x)`:
  - mode 0: x+1 mod 2^DATA_W.
  - mode 1: (x>>1) ^ (x[0] ? POLY : 0).
  - mode 2: PATTERN.
  - mode 3: rotate-left by 1.
- Seeds: mode 0 = 0, mode 1 = SEED, mode 2 = PATTERN, mode 3 = 1.
- Generator:
  - `enable` low: `tx_din_valid` = 0 and the generator is idle.
  - First cycle `enable` is sampled high, or any cycle `mode` differs from its registered value: load `tx_din` = seed, `tx_din_valid` = 1.
  - Advance: when `tx_din_valid & tx_read_enable`, `tx_din` <= `next(tx_din)`. Otherwise `tx_din` holds.
- Checker FSM:
  - HUNT: on `rx_valid`, expected <= `next(rx_d)`, match count <= 0, go to SYNC.
  - SYNC, on `rx_valid`:
    - Match: increment match count. Reaching `LOCK_COUNT` goes to LOCKED (so LOCKED follows 1 + `LOCK_COUNT` words).
    - Mismatch: reseed expected <= `next(rx_d)`, match count <= 0, stay in SYNC.
    - Always: expected <= `next(expected)` on match.
  - LOCKED, on `rx_valid`:
    - Always increment `word_cnt`; expected <= `next(expected)`. No reseed, so a single corrupted word costs exactly one error.
    - Mismatch: increment `word_err_cnt`, add popcount to `bit_err_cnt`, pulse `err_pulse`, increment the consecutive-miss count.
    - Match: clear the consecutive-miss count.
    - Consecutive misses reaching `UNLOCK_ERRS`: go to HUNT.
- Forced HUNT, from any state, by any of: `rx_reframe`, `enable` low, `mode` change.
- Counters saturate at 2^CNT_W-1. `bit_err_cnt` saturates on the add without wrapping.
- `clear` zeroes all three counters. FSM state is unaffected. If `clear` coincides with an update, `clear` wins.
- Lockup: PRBS word 0 maps to 0 forever. The checker treats 0 like any other word; the generator never emits 0 because SEED is non-zero.

## Timing
- Reset (`rst_n` low), asynchronous: `tx_din` = 0, `tx_din_valid` = 0, FSM = HUNT, `locked` = 0, `err_pulse` = 0, all counters = 0, registered mode = 0.
- Generator latency: `enable` high at edge N gives `tx_din_valid` = 1 with the seed after edge N.
- Checker latency: `rx_d` sampled at edge N updates `locked`, the counters and `err_pulse` after edge N; they are visible during cycle N+1.
- Priority when events coincide in one cycle: `rx_reframe`/`enable`/`mode` forced HUNT > `rx_valid` processing. A word arriving with `rx_reframe` is dropped and not counted.
- `rst_n` asserted mid-word: all state lost immediately; no partial update.

## Test plan
- Loopback, mode 0, DATA_W=8, `tx_read_enable` every 10th cycle: expect `locked` = 1 after the 5th received word; after 256 words, `word_err_cnt` = 0 and `word_cnt` = 251.
- Mode 1 with POLY 8'hB8, SEED 1: generated sequence starts 01, B8, 5C, 2E. The checker locks from an arbitrary start offset.
- Locked in mode 0, flip bits 0 and 3 of one word: exactly one `err_pulse`, `word_err_cnt` = 1, `bit_err_cnt` = 2, `locked` stays 1.
- 4 consecutive corrupted words (UNLOCK_ERRS=4): `locked` falls the cycle after the 4th word; the checker relocks 5 good words later.
- `rx_reframe` pulse while locked: `locked` = 0 next cycle and the concurrent word is not counted. `clear` together with a mismatch leaves all counters at 0.
- CNT_W=4 with 20 mismatches: `word_err_cnt` holds at 15. `rst_n` pulsed mid-run: all outputs return to their reset values asynchronously.
